knn_list_ctrl: RTL and testbench

- Sequencer for the K-deep sorted neighbour list built from chained list_element stages.
- Per query: clears the list, streams N candidate (distance, label) pairs into it at one per cycle, waits for the final insertion to commit, then reads the surviving neighbours out in ascending-distance order over a valid/ready port.
- Sits between the distance-computation datapath (upstream) and the label-vote logic (downstream).

---
 rtl/knn_list_ctrl.sv | 129 ++++++++++++
 tb/tb_knn_list_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/knn_list_ctrl.sv
// Query sequencer for the K-deep sorted neighbour list: clear, stream N candidates
// in at one per cycle, let the last insertion settle, then read min(K,N) entries out in order.
module knn_list_ctrl #(
    parameter int DATA_W = 32,
    parameter int LABEL  = 8,
    parameter int K      = 10,
    parameter int CNT_W  = 16,
    localparam int SEL_W = (K > 1) ? $clog2(K) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        n_points,
    output logic                    busy,
    output logic                    done,
    input  logic                    cand_valid,
    output logic                    cand_ready,
    input  logic [DATA_W-1:0]       cand_dist,
    input  logic [LABEL-1:0]        cand_label,
    output logic                    list_clr,
    output logic                    list_start,
    output logic                    list_valid,
    output logic [DATA_W-1:0]       list_dist,
    output logic [LABEL-1:0]        list_label,
    output logic [SEL_W-1:0]        list_sel,
    input  logic [DATA_W+LABEL-1:0] list_data,
    output logic                    nbr_valid,
    input  logic                    nbr_ready,
    output logic [DATA_W-1:0]       nbr_dist,
    output logic [LABEL-1:0]        nbr_label,
    output logic                    nbr_last
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_INSERT = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [CNT_W-1:0] K_C = CNT_W'(K);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  n_lat_q, n_lat_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              clr_q, clr_d;
    logic              lv_q, lv_d;
    logic [DATA_W-1:0] ldist_q, ldist_d;
    logic [LABEL-1:0]  llabel_q, llabel_d;
    logic [CNT_W-1:0]  n_ent;
    logic              cand_hs, nbr_hs;

    // Stages beyond n_lat still hold all-ones and must never be presented.
    assign n_ent      = (n_lat_q < K_C) ? n_lat_q : K_C;
    assign cand_ready = (state_q == S_INSERT) && (in_cnt_q < n_lat_q);
    assign cand_hs    = cand_valid & cand_ready;
    assign nbr_valid  = (state_q == S_READ);
    assign nbr_hs     = nbr_valid & nbr_ready;
    assign nbr_last   = nbr_valid && (out_cnt_q == n_ent - ONE);
    assign list_sel   = nbr_valid ? out_cnt_q[SEL_W-1:0] : '0;
    assign {nbr_dist, nbr_label} = nbr_valid ? list_data : '0;

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign list_start = (state_q == S_INSERT) || (state_q == S_FLUSH);
    assign list_clr   = clr_q;
    assign list_valid = lv_q;
    assign list_dist  = ldist_q;
    assign list_label = llabel_q;

    always_comb begin
        state_d   = state_q;
        n_lat_d   = n_lat_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        clr_d     = 1'b0;
        lv_d      = 1'b0;
        ldist_d   = ldist_q;
        llabel_d  = llabel_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_CLEAR;
                n_lat_d   = n_points;
                in_cnt_d  = '0;
                out_cnt_d = '0;
                clr_d     = 1'b1;
            end
            S_CLEAR:  state_d = (n_lat_q == '0) ? S_FLUSH : S_INSERT;
            S_INSERT: if (cand_hs) begin
                lv_d     = 1'b1;
                ldist_d  = cand_dist;
                llabel_d = cand_label;
                in_cnt_d = in_cnt_q + ONE;
                if (in_cnt_q + ONE == n_lat_q) state_d = S_FLUSH;
            end
            // The last insert strobe is on the list bus during this cycle.
            S_FLUSH:  state_d = (n_lat_q == '0) ? S_DONE : S_READ;
            S_READ: if (nbr_hs) begin
                out_cnt_d = out_cnt_q + ONE;
                if (nbr_last) state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_lat_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            clr_q     <= 1'b0;
            lv_q      <= 1'b0;
            ldist_q   <= '0;
            llabel_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_lat_q   <= n_lat_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            clr_q     <= clr_d;
            lv_q      <= lv_d;
            ldist_q   <= ldist_d;
            llabel_q  <= llabel_d;
        end
    end
endmodule

// File: tb/tb_knn_list_ctrl.sv
// Bench for knn_list_ctrl with K=4: a sorted-list stage model closes the loop and a
// full-sort reference predicts each query's readout.
module tb_knn_list_ctrl;
    localparam int DATA_W = 32;
    localparam int LABEL  = 8;
    localparam int K      = 4;
    localparam int CNT_W  = 16;
    localparam int SEL_W  = $clog2(K);
    localparam int EW     = DATA_W + LABEL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start, cand_valid, nbr_ready;
    logic [CNT_W-1:0]  n_points;
    logic [DATA_W-1:0] cand_dist, list_dist, nbr_dist;
    logic [LABEL-1:0]  cand_label, list_label, nbr_label;
    logic busy, done, cand_ready, list_clr, list_start, list_valid, nbr_valid, nbr_last;
    logic [SEL_W-1:0]  list_sel;
    logic [EW-1:0]     list_data;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    knn_list_ctrl #(.DATA_W(DATA_W), .LABEL(LABEL), .K(K), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points), .busy(busy), .done(done),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_dist(cand_dist),
        .cand_label(cand_label), .list_clr(list_clr), .list_start(list_start),
        .list_valid(list_valid), .list_dist(list_dist), .list_label(list_label),
        .list_sel(list_sel), .list_data(list_data), .nbr_valid(nbr_valid),
        .nbr_ready(nbr_ready), .nbr_dist(nbr_dist), .nbr_label(nbr_label), .nbr_last(nbr_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chained list stages: clear to all-ones, insert keeps ascending order, deepest drops.
    logic [EW-1:0] lst [K];
    assign list_data = lst[list_sel];
    always @(posedge clk) begin
        int p;
        if (list_clr) begin
            for (int i = 0; i < K; i++) lst[i] = '1;
        end else if (list_start && list_valid) begin
            p = K;
            for (int i = K - 1; i >= 0; i--) if (lst[i][EW-1:LABEL] > list_dist) p = i;
            for (int i = K - 1; i > p; i--) lst[i] = lst[i-1];
            if (p < K) lst[p] = {list_dist, list_label};
        end
    end

    // Cycle monitor: strobe timing, strobe exclusivity, readout stability under backpressure.
    logic hs_prev = 1'b0;
    logic stall_prev = 1'b0;
    logic [EW+1:0] nbr_prev;
    always @(posedge clk) begin
        if (rst) begin
            hs_prev    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("list_valid_after_hs", list_valid, hs_prev);
            if (list_valid) chk("list_valid_in_start", list_start, 1);
            if (list_clr) chk("clr_excl_valid", list_valid, 0);
            if (stall_prev) chk("stall_hold", {nbr_valid, nbr_last, nbr_dist, nbr_label}, nbr_prev);
            hs_prev    = cand_valid & cand_ready;
            stall_prev = nbr_valid & ~nbr_ready;
            nbr_prev   = {nbr_valid, nbr_last, nbr_dist, nbr_label};
        end
    end

    logic [DATA_W-1:0] cd [64];
    logic [DATA_W-1:0] ed [64];
    logic [LABEL-1:0]  cl [64];
    logic [LABEL-1:0]  el [64];

    task automatic reset_check();
        chk("rst_ctrl", {busy, done, cand_ready, list_clr, list_start, list_valid,
                         list_sel, nbr_valid, nbr_last}, 0);
        chk("rst_list_bus", {list_dist, list_label}, 0);
        chk("rst_nbr_bus", {nbr_dist, nbr_label}, 0);
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) begin
            cd[i] = DATA_W'(($urandom_range(0, 100000) << 8) | i);
            cl[i] = LABEL'($urandom);
        end
    endtask

    // Reference: fully sort all candidates, keep the nearest min(K,n).
    task automatic build_exp(input int n, output int ne);
        logic [DATA_W-1:0] td;
        logic [LABEL-1:0]  tl;
        for (int i = 0; i < n; i++) begin ed[i] = cd[i]; el[i] = cl[i]; end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n - 1 - i; j++)
                if (ed[j] > ed[j+1]) begin
                    td = ed[j]; ed[j] = ed[j+1]; ed[j+1] = td;
                    tl = el[j]; el[j] = el[j+1]; el[j+1] = tl;
                end
        ne = (n < K) ? n : K;
    endtask

    task automatic run_query(input int n, input bit gap, input int stall, input bit poke,
                             input int abort_hs);
        int ne, sent, got, stl, first_rdy, first_hs, last_hs, first_nv;
        bit fin, poked, aborted;
        build_exp(n, ne);
        sent = 0; got = 0; stl = stall; first_rdy = -1; first_hs = -1; last_hs = -1;
        first_nv = -1; fin = 0; poked = 0; aborted = 0;
        for (int idx = 0; idx < 3000 && !fin; idx++) begin
            @(negedge clk);
            if (abort_hs > 0 && sent == abort_hs) begin
                rst = 1'b1; cand_valid = 1'b0; start = 1'b0; nbr_ready = 1'b0;
                #1;
                reset_check();
                @(negedge clk);
                rst = 1'b0;
                fin = 1; aborted = 1;
            end else begin
                chk("list_clr_pulse", list_clr, idx == 1);
                chk("busy", busy, idx >= 1);
                if (sent >= n) chk("ready_saturated", cand_ready, 0);
                if (cand_ready && first_rdy < 0) first_rdy = idx;
                if (nbr_valid) begin
                    if (first_nv < 0) first_nv = idx;
                    chk("entry_in_range", got < ne, 1);
                    if (got < ne) begin
                        chk("nbr_entry", {nbr_dist, nbr_label}, {ed[got], el[got]});
                        chk("nbr_last", nbr_last, got == ne - 1);
                    end
                end
                if (done) begin
                    chk("entries_read", got, ne);
                    chk("cands_sent", sent, n);
                    if (n == 0) begin
                        chk("done_lat_empty", idx, 3);
                        chk("no_readout_empty", first_nv, -1);
                    end else begin
                        chk("start_to_ready", first_rdy, 2);
                        chk("last_hs_to_nbr", first_nv, last_hs + 2);
                        if (!gap) chk("back_to_back", last_hs - first_hs, n - 1);
                    end
                    fin = 1;
                end
                // drive next cycle
                if (poke && nbr_valid && !poked) begin start = 1'b1; poked = 1; end
                else start = (idx == 0);
                n_points = (idx == 0) ? CNT_W'(n) : CNT_W'($urandom_range(0, 50));
                cand_valid = !fin && (sent < n) && (!gap || idx[0]);
                if (cand_valid) begin
                    cand_dist = cd[sent]; cand_label = cl[sent];
                    if (cand_ready) begin
                        if (first_hs < 0) first_hs = idx;
                        last_hs = idx;
                        sent++;
                    end
                end else begin
                    cand_dist = $urandom; cand_label = LABEL'($urandom);
                end
                if (nbr_valid && stl == 0) begin nbr_ready = 1'b1; got++; stl = stall; end
                else begin nbr_ready = 1'b0; if (nbr_valid) stl--; end
            end
        end
        chk("query_finished", fin, 1);
        if (!aborted) begin
            start = 1'b0; cand_valid = 1'b0; nbr_ready = 1'b0;
            @(negedge clk);
            chk("busy_drops", busy, 0);
            chk("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        start = 0; n_points = '0; cand_valid = 0; cand_dist = '0; cand_label = '0; nbr_ready = 0;
        #12;
        reset_check();
        @(negedge clk);
        rst = 1'b0;

        // abort after 3 of 8, then a fresh 2-entry query must not see stale entries
        load_rand(8);
        run_query(8, 0, 0, 0, 3);
        cd[0] = 9; cl[0] = 8'h11; cd[1] = 4; cl[1] = 8'h22;
        run_query(2, 0, 0, 0, 0);

        // 6 candidates into a 4-deep list, back to back then gapped with backpressure
        cd[0] = 50; cd[1] = 20; cd[2] = 70; cd[3] = 10; cd[4] = 40; cd[5] = 30;
        for (int i = 0; i < 6; i++) cl[i] = LABEL'(i + 1);
        run_query(6, 0, 0, 0, 0);
        run_query(6, 1, 3, 0, 0);

        run_query(0, 0, 0, 0, 0);

        cd[0] = 7; cl[0] = 8'hA7; cd[1] = 3; cl[1] = 8'hB3;
        run_query(2, 0, 0, 0, 0);

        // start pulsed during readout
        load_rand(5);
        run_query(5, 0, 1, 1, 0);

        for (int q = 0; q < 10; q++) begin
            int n;
            n = $urandom_range(0, 12);
            load_rand(n);
            run_query(n, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
